tar_raster_tx: RTL and testbench



---
 rtl/tar_raster_tx.sv | 267 ++++++++++++++++++++++++++
 tb/tb_tar_raster_tx.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tar_raster_tx.sv
`default_nettype none
// ============================================================================
// Module      : tar_raster_tx
// Description : Output-side raster transmitter for the downscaler. Buffers the
//               bursty pixel stream in a FIFO and re-emits it as a continuous
//               vsync/hsync/data_enable raster at the target resolution.
// Ports       : clk, rst_n (sync, active-low)
//               in_valid, in_R/G/B   - incoming pixel stream
//               frame_done           - upstream frame complete (rising edge)
//               tar_width/height     - active raster size, sampled at start
//               vsync/hsync/data_enable, out_R/G/B - registered raster
//               tx_frame_done        - 1-cycle pulse after the frame
//               overflow/underflow   - sticky flags, cleared at frame start
// Option      : TX_UNDERFLOW_HOLD_EN - underflow repeats the last popped pixel
//               instead of emitting black.
// Revision    : 1.0 - initial release
// ============================================================================
module tar_raster_tx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int START_LEVEL = 8,
    parameter int HFRONT      = 2,
    parameter int HSYNC       = 2,
    parameter int HBACK       = 2,
    parameter int VFRONT      = 1,
    parameter int VSYNC       = 1,
    parameter int VBACK       = 1,
    parameter int W_BITS      = 12,
    parameter int H_BITS      = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_R,
    input  logic [7:0]        in_G,
    input  logic [7:0]        in_B,
    input  logic              frame_done,
    input  logic [W_BITS-1:0] tar_width,
    input  logic [H_BITS-1:0] tar_height,
    output logic              vsync,
    output logic              hsync,
    output logic              data_enable,
    output logic [7:0]        out_R,
    output logic [7:0]        out_G,
    output logic [7:0]        out_B,
    output logic              tx_frame_done,
    output logic              overflow,
    output logic              underflow
);

    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_CW     = c_AW + 1;
    localparam int c_HPORCH = HFRONT + HSYNC + HBACK;
    localparam int c_VPORCH = VFRONT + VSYNC + VBACK;
    // Counters must be able to hold the full line/frame totals.
    localparam int c_HCW    = $clog2((1 << W_BITS) + c_HPORCH);
    localparam int c_VCW    = $clog2((1 << H_BITS) + c_VPORCH);

    localparam logic [c_CW-1:0]  c_START  = c_CW'(START_LEVEL);
    localparam logic [c_CW-1:0]  c_DEPTH  = c_CW'(FIFO_DEPTH);
    localparam logic [c_HCW-1:0] c_HS_LO  = c_HCW'(HFRONT);
    localparam logic [c_HCW-1:0] c_HS_HI  = c_HCW'(HFRONT + HSYNC);
    localparam logic [c_HCW-1:0] c_HACT   = c_HCW'(c_HPORCH);
    localparam logic [c_VCW-1:0] c_VS_LO  = c_VCW'(VFRONT);
    localparam logic [c_VCW-1:0] c_VS_HI  = c_VCW'(VFRONT + VSYNC);
    localparam logic [c_VCW-1:0] c_VACT   = c_VCW'(c_VPORCH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    logic [23:0]       r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wptr;
    logic [c_AW-1:0]   r_rptr;
    logic [c_CW-1:0]   r_count;

    logic [c_HCW-1:0]  r_hcnt;
    logic [c_VCW-1:0]  r_vcnt;
    logic [W_BITS-1:0] r_tw;
    logic [H_BITS-1:0] r_th;

    logic              r_fd_prev;
    logic              r_fd_latch;

    logic [c_HCW-1:0]  w_htotal;
    logic [c_VCW-1:0]  w_vtotal;
    logic              w_hlast;
    logic              w_vlast;
    logic              w_run;
    logic              w_act;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_ovf_evt;
    logic              w_udf_evt;
    logic              w_fd_rise;
    logic              w_start;
    logic [23:0]       w_head;
    logic [23:0]       w_sub;
    logic [23:0]       w_pix;

    // ------------------------------------------------------------------------
    // Raster decode
    // ------------------------------------------------------------------------
    assign w_htotal  = c_HCW'(c_HPORCH) + c_HCW'(r_tw);
    assign w_vtotal  = c_VCW'(c_VPORCH) + c_VCW'(r_th);
    assign w_hlast   = (r_hcnt == w_htotal - c_HCW'(1));
    assign w_vlast   = (r_vcnt == w_vtotal - c_VCW'(1));
    assign w_run     = (r_state == c_ST_RUN);
    assign w_act     = w_run && (r_hcnt >= c_HACT) && (r_vcnt >= c_VACT);

    // ------------------------------------------------------------------------
    // FIFO control. A full FIFO still accepts a push when the head is popped
    // in the same cycle, so a steady stream during active video never drops.
    // ------------------------------------------------------------------------
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_DEPTH);
    assign w_pop     = w_act && !w_empty;
    assign w_push    = in_valid && (!w_full || w_pop);
    assign w_ovf_evt = in_valid && w_full && !w_pop;
    assign w_udf_evt = w_act && w_empty;
    assign w_head    = r_mem[r_rptr];

    assign w_fd_rise = frame_done && !r_fd_prev;
    // The latch is consulted only once registered; an edge in the start
    // cycle itself is kept for the following frame.
    assign w_start   = (r_state == c_ST_IDLE) && ((r_count >= c_START) || r_fd_latch);

`ifdef TX_UNDERFLOW_HOLD_EN
    logic [23:0] r_last_pix;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_pix <= '0;
        end else if (w_pop) begin
            r_last_pix <= w_head;
        end
    end

    assign w_sub = r_last_pix;
`else
    assign w_sub = '0;
`endif

    assign w_pix = w_pop ? w_head : w_sub;

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_R, in_G, in_B};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_start) w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (w_hlast && w_vlast) w_state_nxt = c_ST_DONE;
            // One extra state lets the last raster output drain before the
            // done pulse, so a new frame can follow the pulse directly.
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Raster counters, frame size and frame_done latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_run) begin
            if (w_hlast) begin
                r_hcnt <= '0;
                r_vcnt <= w_vlast ? '0 : r_vcnt + c_VCW'(1);
            end else begin
                r_hcnt <= r_hcnt + c_HCW'(1);
            end
        end else begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tw       <= '0;
            r_th       <= '0;
            r_fd_prev  <= 1'b0;
            r_fd_latch <= 1'b0;
        end else begin
            r_fd_prev <= frame_done;
            if (w_start) begin
                r_tw       <= tar_width;
                r_th       <= tar_height;
                r_fd_latch <= w_fd_rise;
            end else begin
                r_fd_latch <= r_fd_latch | w_fd_rise;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs: each reflects the counter state of the prior cycle.
    // Flag events coinciding with a frame start survive the clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync         <= 1'b0;
            hsync         <= 1'b0;
            data_enable   <= 1'b0;
            out_R         <= '0;
            out_G         <= '0;
            out_B         <= '0;
            tx_frame_done <= 1'b0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
        end else begin
            vsync         <= w_run && (r_vcnt >= c_VS_LO) && (r_vcnt < c_VS_HI);
            hsync         <= w_run && (r_hcnt >= c_HS_LO) && (r_hcnt < c_HS_HI);
            data_enable   <= w_act;
            {out_R, out_G, out_B} <= w_act ? w_pix : 24'd0;
            tx_frame_done <= (r_state == c_ST_DONE);
            overflow      <= w_start ? w_ovf_evt : (overflow | w_ovf_evt);
            underflow     <= w_start ? 1'b0 : (underflow | w_udf_evt);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tar_raster_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_tar_raster_tx
// Description : Self-checking bench for tar_raster_tx. A frame-level reference
//               model (pixel queue plus frame-position arithmetic) predicts
//               every registered output; scenario tasks add targeted checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tar_raster_tx;

    localparam int HF = 2, HS = 2, HB = 2, VF = 1, VS = 1, VB = 1, DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        vin = 1'b0;
    logic        fd = 1'b0;
    logic [23:0] pix = '0;
    logic [11:0] tar_w = 12'd4;
    logic [11:0] tar_h = 12'd2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    logic       a_vs, a_hs, a_de, a_done, a_ovf, a_udf;
    logic [7:0] a_r, a_g, a_b;
    logic       b_vs, b_hs, b_de, b_done, b_ovf, b_udf;
    logic [7:0] b_r, b_g, b_b;

    tar_raster_tx u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(vin & ~sel),
        .in_R(pix[23:16]), .in_G(pix[15:8]), .in_B(pix[7:0]),
        .frame_done(fd & ~sel), .tar_width(tar_w), .tar_height(tar_h),
        .vsync(a_vs), .hsync(a_hs), .data_enable(a_de),
        .out_R(a_r), .out_G(a_g), .out_B(a_b),
        .tx_frame_done(a_done), .overflow(a_ovf), .underflow(a_udf)
    );

    tar_raster_tx #(.START_LEVEL(16)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vin & sel),
        .in_R(pix[23:16]), .in_G(pix[15:8]), .in_B(pix[7:0]),
        .frame_done(fd & sel), .tar_width(tar_w), .tar_height(tar_h),
        .vsync(b_vs), .hsync(b_hs), .data_enable(b_de),
        .out_R(b_r), .out_G(b_g), .out_B(b_b),
        .tx_frame_done(b_done), .overflow(b_ovf), .underflow(b_udf)
    );

    logic [29:0] obs;
    assign obs = sel ? {b_vs, b_hs, b_de, b_r, b_g, b_b, b_done, b_ovf, b_udf}
                     : {a_vs, a_hs, a_de, a_r, a_g, a_b, a_done, a_ovf, a_udf};
    logic        o_vs, o_hs, o_de, o_done, o_ovf, o_udf;
    logic [23:0] o_pix;
    assign {o_vs, o_hs, o_de, o_pix, o_done, o_ovf, o_udf} = obs;

    // ------------------------------------------------------------------------
    // Reference model: a frame is HT*VT positions; position k maps to
    // (k % HT, k / HT). Pixels live in a queue of at most DEPTH entries.
    // ------------------------------------------------------------------------
    logic [29:0] m_out = '0;
    logic [23:0] m_q[$];
    int          m_phase = 0;   // 0 waiting, 1 in frame, 2 frame finished
    int          m_k = 0, m_tw = 0, m_th = 0;
    bit          m_latch = 0, m_fdp = 0, m_ovf = 0, m_udf = 0;
    logic [23:0] m_last = '0;
    int          t_sl, t_ht, t_vt, t_h, t_v;
    bit          t_rise, t_pop, t_act, t_start, t_oev, t_vs, t_hs, t_dn;
    logic [23:0] t_px;

    always @(posedge clk) begin
        t_vs = 0; t_hs = 0; t_dn = 0; t_px = '0; t_pop = 0; t_act = 0; t_start = 0;
        t_ht = 1; t_vt = 1;
        t_sl = sel ? 16 : 8;
        if (!rst_n) begin
            m_phase = 0; m_k = 0; m_q.delete(); m_latch = 0; m_fdp = 0;
            m_ovf = 0; m_udf = 0; m_last = '0; m_out = '0;
        end else begin
            t_rise = fd && !m_fdp;
            m_fdp  = fd;
            if (m_phase == 1) begin
                t_ht = HF + HS + HB + m_tw;
                t_vt = VF + VS + VB + m_th;
                t_h  = m_k % t_ht;
                t_v  = m_k / t_ht;
                t_vs = (t_v >= VF) && (t_v < VF + VS);
                t_hs = (t_h >= HF) && (t_h < HF + HS);
                t_act = (t_h >= HF + HS + HB) && (t_v >= VF + VS + VB);
                if (t_act) begin
                    if (m_q.size() > 0) begin
                        t_px = m_q[0]; t_pop = 1; m_last = t_px;
                    end else begin
                        m_udf = 1;
`ifdef TX_UNDERFLOW_HOLD_EN
                        t_px = m_last;
`else
                        t_px = '0;
`endif
                    end
                end
            end else if (m_phase == 2) begin
                t_dn = 1;
            end else begin
                t_start = (m_q.size() >= t_sl) || m_latch;
            end
            t_oev = vin && (m_q.size() == DEPTH) && !t_pop;
            if (t_pop) void'(m_q.pop_front());
            if (vin && !t_oev) m_q.push_back(pix);
            if (t_start) begin
                m_ovf = t_oev; m_udf = 0; m_latch = t_rise;
                m_tw = int'(tar_w); m_th = int'(tar_h);
                m_phase = 1; m_k = 0;
            end else begin
                m_ovf = m_ovf | t_oev;
                m_latch = m_latch | t_rise;
                if (m_phase == 1) begin
                    m_k++;
                    if (m_k == t_ht * t_vt) m_phase = 2;
                end else if (m_phase == 2) begin
                    m_phase = 0;
                end
            end
            m_out = {t_vs, t_hs, t_act, t_px, t_dn, m_ovf, m_udf};
        end
    end

    task automatic do_reset(input logic s);
        @(negedge clk);
        rst_n = 1'b0; vin = 1'b0; fd = 1'b0; sel = s;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({a_vs, a_hs, a_de, a_r, a_g, a_b, a_done, a_ovf, a_udf} !== 30'd0) begin
            bad++; $display("FAIL reset_a got=%h exp=0", {a_vs, a_hs, a_de, a_r, a_g, a_b, a_done, a_ovf, a_udf});
        end
        total++;
        if ({b_vs, b_hs, b_de, b_r, b_g, b_b, b_done, b_ovf, b_udf} !== 30'd0) begin
            bad++; $display("FAIL reset_b got=%h exp=0", {b_vs, b_hs, b_de, b_r, b_g, b_b, b_done, b_ovf, b_udf});
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (obs !== m_out) begin bad++; $display("FAIL reset_model got=%h exp=%h", obs, m_out); end
        end
    endtask

    task automatic test_basic_frame();
        int first_done = 0, n_done = 0, first_hs = 0, first_vs = 0, n_vs = 0;
        logic [23:0] got[$];
        tar_w = 12'd4; tar_h = 12'd2;
        for (int j = 1; j <= 66; j++) begin
            @(negedge clk);
            total++;
            if (obs !== m_out) begin bad++; $display("FAIL basic_model cyc=%0d got=%h exp=%h", j, obs, m_out); end
            if (o_de) got.push_back(o_pix);
            if (o_hs && first_hs == 0) first_hs = j;
            if (o_vs) begin n_vs++; if (first_vs == 0) first_vs = j; end
            if (o_done) begin n_done++; if (first_done == 0) first_done = j; end
            vin = (j <= 8);
            pix = {3{8'(j)}};
        end
        vin = 1'b0;
        total++;
        if (first_hs != 13) begin bad++; $display("FAIL basic_first_hsync got=%0d exp=13", first_hs); end
        total++;
        if (first_vs != 21 || n_vs != 10) begin bad++; $display("FAIL basic_vsync first=%0d n=%0d exp=21/10", first_vs, n_vs); end
        total++;
        if (first_done != 61 || n_done != 1) begin bad++; $display("FAIL basic_done first=%0d n=%0d exp=61/1", first_done, n_done); end
        total++;
        if (got.size() != 8) begin bad++; $display("FAIL basic_de_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            total++;
            if (got[i] !== {3{8'(i + 1)}}) begin bad++; $display("FAIL basic_pix%0d got=%h exp=%h", i, got[i], {3{8'(i + 1)}}); end
        end
        total++;
        if ({o_ovf, o_udf} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b exp=00", {o_ovf, o_udf}); end
    endtask

    task automatic test_frame_done_start();
        int first_hs = 0, first_done = 0;
        logic [23:0] sent[$], got[$];
        tar_w = 12'd3; tar_h = 12'd1;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            total++;
            if (obs !== m_out) begin bad++; $display("FAIL fd_model cyc=%0d got=%h exp=%h", j, obs, m_out); end
            if (o_de) got.push_back(o_pix);
            if (o_hs && first_hs == 0) first_hs = j;
            if (o_done && first_done == 0) first_done = j;
            vin = (j <= 3);
            pix = 24'($urandom);
            if (vin) sent.push_back(pix);
            fd = (j == 5);
        end
        vin = 1'b0; fd = 1'b0;
        total++;
        if (first_hs != 10) begin bad++; $display("FAIL fd_first_hsync got=%0d exp=10", first_hs); end
        total++;
        if (first_done != 44) begin bad++; $display("FAIL fd_done got=%0d exp=44", first_done); end
        total++;
        if (got.size() != 3 || got != sent) begin bad++; $display("FAIL fd_pixels n=%0d exp=3", got.size()); end
        total++;
        if (o_udf !== 1'b0) begin bad++; $display("FAIL fd_underflow got=%b exp=0", o_udf); end
    endtask

    task automatic test_underflow();
        logic [23:0] sent[$], got[$], sub;
        tar_w = 12'd4; tar_h = 12'd2;
        for (int j = 1; j <= 66; j++) begin
            @(negedge clk);
            total++;
            if (obs !== m_out) begin bad++; $display("FAIL udf_model cyc=%0d got=%h exp=%h", j, obs, m_out); end
            if (o_de) got.push_back(o_pix);
            vin = (j <= 6);
            pix = 24'($urandom);
            if (vin) sent.push_back(pix);
            fd = (j == 8);
        end
        vin = 1'b0; fd = 1'b0;
`ifdef TX_UNDERFLOW_HOLD_EN
        sub = sent[5];
`else
        sub = 24'd0;
`endif
        sent.push_back(sub);
        sent.push_back(sub);
        total++;
        if (got.size() != 8) begin bad++; $display("FAIL udf_de_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            total++;
            if (got[i] !== sent[i]) begin bad++; $display("FAIL udf_pix%0d got=%h exp=%h", i, got[i], sent[i]); end
        end
        total++;
        if (o_udf !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", o_udf); end
    endtask

    task automatic test_overflow();
        int n_done = 0;
        logic [23:0] got[$];
        do_reset(1'b1);
        tar_w = 12'd4; tar_h = 12'd4;
        for (int j = 1; j <= 182; j++) begin
            @(negedge clk);
            total++;
            if (obs !== m_out) begin bad++; $display("FAIL ovf_model cyc=%0d got=%h exp=%h", j, obs, m_out); end
            if (o_de) got.push_back(o_pix);
            if (o_done) n_done++;
            if (j == 30) begin
                total++;
                if (o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", o_ovf); end
            end
            if (j == 108) begin
                total++;
                if (o_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", o_ovf); end
            end
            vin = (j <= 20) || (j >= 90 && j <= 105);
            pix = {3{8'(j)}};
        end
        vin = 1'b0;
        total++;
        if (got.size() != 32 || n_done != 2) begin bad++; $display("FAIL ovf_frames de=%0d done=%0d exp=32/2", got.size(), n_done); end
        for (int i = 0; i < 32 && i < got.size(); i++) begin
            total++;
            if (got[i] !== {3{8'(i < 16 ? i + 1 : i + 74)}}) begin
                bad++; $display("FAIL ovf_pix%0d got=%h exp=%h", i, got[i], {3{8'(i < 16 ? i + 1 : i + 74)}});
            end
        end
        do_reset(1'b0);
    endtask

    task automatic test_mid_reset();
        int n_hs_idle = 0, n_done = 0;
        logic [23:0] sent[$], got[$];
        tar_w = 12'd4; tar_h = 12'd2;
        for (int j = 1; j <= 130; j++) begin
            @(negedge clk);
            total++;
            if (obs !== m_out) begin bad++; $display("FAIL mrst_model cyc=%0d got=%h exp=%h", j, obs, m_out); end
            if (j == 49) begin
                total++;
                if (obs !== 30'd0) begin bad++; $display("FAIL mrst_outputs got=%h exp=0", obs); end
            end
            if (j >= 50 && j <= 72 && (o_hs || o_vs || o_de)) n_hs_idle++;
            if (j >= 50 && o_de) got.push_back(o_pix);
            if (j >= 50 && o_done) n_done++;
            rst_n = (j != 48);
            vin = (j <= 8) || (j >= 50 && j <= 56) || (j == 71);
            pix = 24'($urandom);
            if (vin && j >= 50) sent.push_back(pix);
        end
        vin = 1'b0; rst_n = 1'b1;
        total++;
        if (n_hs_idle != 0) begin bad++; $display("FAIL mrst_idle activity=%0d exp=0", n_hs_idle); end
        total++;
        if (n_done != 1 || got.size() != 8 || got != sent) begin
            bad++; $display("FAIL mrst_frame done=%0d de=%0d exp=1/8", n_done, got.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] sent[$], got[$];
        tar_w = 12'd4; tar_h = 12'd4;
        for (int j = 1; j <= 85; j++) begin
            @(negedge clk);
            total++;
            if (obs !== m_out) begin bad++; $display("FAIL b2b_model cyc=%0d got=%h exp=%h", j, obs, m_out); end
            if (o_de) got.push_back(o_pix);
            vin = (j <= 16) || (j >= 46 && j <= 49);
            pix = 24'($urandom);
            if (vin) sent.push_back(pix);
        end
        vin = 1'b0;
        total++;
        if (o_ovf !== 1'b0) begin bad++; $display("FAIL b2b_overflow got=%b exp=0", o_ovf); end
        total++;
        if (got.size() != 16) begin bad++; $display("FAIL b2b_count got=%0d exp=16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            total++;
            if (got[i] !== sent[i]) begin bad++; $display("FAIL b2b_pix%0d got=%h exp=%h", i, got[i], sent[i]); end
        end
        do_reset(1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 5; it++) begin
            int n_push, sent_n, cycles, fd_at;
            tar_w = 12'($urandom_range(1, 6));
            tar_h = 12'($urandom_range(1, 3));
            n_push = $urandom_range(0, int'(tar_w) * int'(tar_h) + 4);
            cycles = (6 + int'(tar_w)) * (3 + int'(tar_h)) * 2 + 60;
            fd_at  = $urandom_range(5, cycles / 2);
            sent_n = 0;
            for (int j = 1; j <= cycles; j++) begin
                @(negedge clk);
                total++;
                if (obs !== m_out) begin bad++; $display("FAIL rand_model it=%0d cyc=%0d got=%h exp=%h", it, j, obs, m_out); end
                vin = (sent_n < n_push) && ($urandom_range(0, 2) != 0);
                if (vin) sent_n++;
                pix = 24'($urandom);
                fd = (j == fd_at);
            end
            vin = 1'b0; fd = 1'b0;
        end
        do_reset(1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_frame_done_start();
        test_underflow();
        test_overflow();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
